// File: rtl/ucpu_pkg.sv
// Shared micro-CPU types and bus geometry for the commit stage and its helpers.
`ifndef UCPU_DEFINES
`define UCPU_DEFINES
`define DATA_WIDTH      8
`define ADDR_WIDTH      3
`define WRITE_WIDTH     8
`define MPC_WIDTH       8
`define A_REG_MAP       3'd0
`define B_REG_MAP       3'd1
`define REG_SEL_MAP     3'd2
`define REG_WR_DATA_MAP 3'd3
`define M_PC_MAP        3'd4
`endif

package ucpu_pkg;
    typedef enum logic [2:0] {
        MI_MOVE   = 3'b000,
        MI_ALU    = 3'b001,
        MI_REGFILE= 3'b010,
        MI_BRANCH = 3'b011,
        MI_JUMP   = 3'b100,
        MI_CALL   = 3'b101,
        MI_RET    = 3'b110,
        MI_HALT   = 3'b111
    } minstr_t;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} seq_state_t;

    localparam int MSTACK_DEPTH_DEF = 4;
endpackage

// File: rtl/mstack.sv
// Micro call/return LIFO: synchronous push/pop/clear, combinational top-of-stack.
module mstack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW:0]   r_sp;
    logic [PW-1:0] w_top_idx;

    assign w_top_idx = PW'(r_sp - 1'b1);
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = (r_sp == (PW+1)'(DEPTH));
    assign o_empty   = (r_sp == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_mem[PW'(r_sp)] <= i_data;
            r_sp             <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end
endmodule

// File: rtl/bus_commit_sequencer.sv
// Commits the resolved micro-bus value into datapath/micro-arch registers and
// sequences the micro-PC through a RUN/HALT machine with a call/return stack.
module bus_commit_sequencer
    import ucpu_pkg::*;
#(
    parameter int MSTACK_DEPTH = MSTACK_DEPTH_DEF,
    parameter int MPC_W        = `MPC_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    uop_valid,
    output logic                    uop_ready,
    input  logic [2:0]              minstr_type,
    input  logic [`ADDR_WIDTH-1:0]  reg_dst,
    input  logic                    alu_en,
    input  logic                    reg_file_en,
    input  logic                    reg_file_rw,
    input  logic                    is_branch,
    input  logic [`WRITE_WIDTH-1:0] write_bus_out,
    input  logic                    resume,
    output logic [`DATA_WIDTH-1:0]  a_reg,
    output logic [`DATA_WIDTH-1:0]  b_reg,
    output logic [3:0]              reg_sel,
    output logic [`DATA_WIDTH-1:0]  reg_wr_data,
    output logic                    reg_file_we,
    output logic                    alu_start,
    output logic [MPC_W-1:0]        m_pc,
    output logic                    halted,
    output logic                    stack_err
);
    localparam int DW = `DATA_WIDTH;

    seq_state_t       r_state, w_state_nxt;
    minstr_t          w_type;
    logic [DW-1:0]    r_a, r_b, r_wd;
    logic [3:0]       r_sel;
    logic             r_we, r_as, r_err;
    logic [MPC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_top;
    logic             w_accept, w_commit, w_full, w_empty;
    logic             w_push, w_pop, w_fault, w_clr;

    assign w_type   = minstr_t'(minstr_type);
    assign w_accept = uop_valid && (r_state == RUN);
    assign w_commit = w_accept && (w_type inside {MI_MOVE, MI_ALU, MI_REGFILE});
    assign w_pc_inc = r_pc + 1'b1;
    assign w_push   = w_accept && (w_type == MI_CALL) && !w_full;
    assign w_pop    = w_accept && (w_type == MI_RET) && !w_empty;
    assign w_fault  = w_accept && (((w_type == MI_CALL) && w_full) ||
                                   ((w_type == MI_RET) && w_empty));
    assign w_clr    = (r_state == HALT) && resume;

    mstack #(.DEPTH(MSTACK_DEPTH), .W(MPC_W)) u_mstack (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clr   (w_clr),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= RUN;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:  if (w_accept && ((w_type == MI_HALT) || w_fault)) w_state_nxt = HALT;
            HALT: if (resume) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // A faulting CALL/RET leaves the PC untouched; the HALT op holds it too.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_clr) begin
            w_pc_nxt = '0;
        end else if (w_accept) begin
            case (w_type)
                MI_MOVE, MI_ALU, MI_REGFILE:
                    w_pc_nxt = (reg_dst == `M_PC_MAP && is_branch) ? MPC_W'(write_bus_out) : w_pc_inc;
                MI_BRANCH, MI_JUMP: w_pc_nxt = MPC_W'(write_bus_out);
                MI_CALL:  if (!w_full)  w_pc_nxt = MPC_W'(write_bus_out);
                MI_RET:   if (!w_empty) w_pc_nxt = w_top;
                default:  w_pc_nxt = r_pc;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sel <= '0;
            r_wd  <= '0;
            r_we  <= 1'b0;
            r_as  <= 1'b0;
            r_pc  <= '0;
            r_err <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_as <= w_accept && (w_type == MI_ALU);
            r_pc <= w_pc_nxt;
            if (w_clr)        r_err <= 1'b0;
            else if (w_fault) r_err <= 1'b1;
            if (w_commit) begin
                if (reg_dst == `A_REG_MAP && alu_en) r_a <= DW'(write_bus_out);
                if (reg_dst == `B_REG_MAP && alu_en) r_b <= DW'(write_bus_out);
                if (reg_dst == `REG_SEL_MAP && reg_file_en) r_sel <= 4'(write_bus_out);
                if (reg_dst == `REG_WR_DATA_MAP && reg_file_en && reg_file_rw) begin
                    r_wd <= DW'(write_bus_out);
                    r_we <= 1'b1;
                end
            end
        end
    end

    assign uop_ready   = (r_state == RUN);
    assign halted      = (r_state == HALT);
    assign stack_err   = r_err;
    assign a_reg       = r_a;
    assign b_reg       = r_b;
    assign reg_sel     = r_sel;
    assign reg_wr_data = r_wd;
    assign reg_file_we = r_we;
    assign alu_start   = r_as;
    assign m_pc        = r_pc;
endmodule

// File: tb/tb_bus_commit_sequencer.sv
// Table-driven plus hand-sequenced check of bus_commit_sequencer with a result queue.
module tb_bus_commit_sequencer;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uop_valid = 1'b0, resume = 1'b0;
    logic [2:0] minstr_type = '0, reg_dst = '0;
    logic       alu_en = 1'b0, reg_file_en = 1'b0, reg_file_rw = 1'b0, is_branch = 1'b0;
    logic [7:0] write_bus_out = '0;
    logic       uop_ready, reg_file_we, alu_start, halted, stack_err;
    logic [7:0] a_reg, b_reg, reg_wr_data, m_pc;
    logic [3:0] reg_sel;

    bus_commit_sequencer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .minstr_type(minstr_type), .reg_dst(reg_dst), .alu_en(alu_en), .reg_file_en(reg_file_en),
        .reg_file_rw(reg_file_rw), .is_branch(is_branch), .write_bus_out(write_bus_out),
        .resume(resume), .a_reg(a_reg), .b_reg(b_reg), .reg_sel(reg_sel),
        .reg_wr_data(reg_wr_data), .reg_file_we(reg_file_we), .alu_start(alu_start),
        .m_pc(m_pc), .halted(halted), .stack_err(stack_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [2:0]  ty;
        logic [2:0]  dst;
        logic        ae, fe, rw, br;
        logic [7:0]  bus;
        logic [40:0] exp;
    } vec_t;

    vec_t        tbl [15];
    logic [40:0] q [$];
    int          n_vec = 0, n_bad = 0;

    function automatic logic [40:0] ex(logic h, logic e, logic [7:0] a, logic [7:0] b,
                                       logic [3:0] sel, logic [7:0] wd, logic we, logic as,
                                       logic [7:0] pc);
        return {h, e, ~h, we, as, a, b, sel, wd, pc};
    endfunction

    function automatic vec_t mk(logic [2:0] ty, logic [2:0] dst, logic ae, logic fe, logic rw,
                                logic br, logic [7:0] bus, logic [40:0] e);
        vec_t v;
        v.ty = ty; v.dst = dst; v.ae = ae; v.fe = fe; v.rw = rw; v.br = br; v.bus = bus; v.exp = e;
        return v;
    endfunction

    function automatic logic [40:0] outs();
        return {halted, stack_err, uop_ready, reg_file_we, alu_start,
                a_reg, b_reg, reg_sel, reg_wr_data, m_pc};
    endfunction

    task automatic check(string nm, logic [40:0] act, logic [40:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (h,e,rdy,we,as,a,b,sel,wd,pc)", nm, act, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(string nm, logic v, logic rs, logic [2:0] ty, logic [2:0] dst,
                        logic ae, logic fe, logic rw, logic br, logic [7:0] bus, logic [40:0] e);
        uop_valid = v; resume = rs; minstr_type = ty; reg_dst = dst;
        alu_en = ae; reg_file_en = fe; reg_file_rw = rw; is_branch = br; write_bus_out = bus;
        q.push_back(e);
        @(posedge sys_clk); #1;
        check(nm, outs(), q.pop_front());
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0; uop_valid = 1'b0; resume = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(3'b000, 3'd0, 1,0,0,0, 8'h5A, ex(0,0,8'h5A,8'h00,4'h0,8'h00,0,0,8'h01));
        tbl[1]  = mk(3'b001, 3'd1, 1,0,0,0, 8'hC7, ex(0,0,8'h5A,8'hC7,4'h0,8'h00,0,1,8'h02));
        tbl[2]  = mk(3'b001, 3'd0, 0,0,0,0, 8'h11, ex(0,0,8'h5A,8'hC7,4'h0,8'h00,0,1,8'h03));
        tbl[3]  = mk(3'b010, 3'd2, 0,1,0,0, 8'hAB, ex(0,0,8'h5A,8'hC7,4'hB,8'h00,0,0,8'h04));
        tbl[4]  = mk(3'b010, 3'd3, 0,1,0,0, 8'h33, ex(0,0,8'h5A,8'hC7,4'hB,8'h00,0,0,8'h05));
        tbl[5]  = mk(3'b010, 3'd3, 0,1,1,0, 8'h33, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,1,0,8'h06));
        tbl[6]  = mk(3'b000, 3'd5, 1,1,1,1, 8'hFF, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h07));
        tbl[7]  = mk(3'b011, 3'd0, 0,0,0,0, 8'h20, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h20));
        tbl[8]  = mk(3'b100, 3'd0, 0,0,0,0, 8'h03, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h03));
        tbl[9]  = mk(3'b000, 3'd4, 0,0,0,0, 8'h80, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h04));
        tbl[10] = mk(3'b000, 3'd4, 0,0,0,1, 8'h05, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h05));
        tbl[11] = mk(3'b101, 3'd0, 0,0,0,0, 8'h40, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h40));
        tbl[12] = mk(3'b110, 3'd0, 0,0,0,0, 8'h00, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h06));
        tbl[13] = mk(3'b100, 3'd0, 0,0,0,0, 8'hFF, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'hFF));
        tbl[14] = mk(3'b000, 3'd7, 0,0,0,0, 8'h00, ex(0,0,8'h5A,8'hC7,4'hB,8'h33,0,0,8'h00));

        do_reset();
        check("reset", outs(), ex(0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 15; i++)
            step($sformatf("vec%0d", i), 1, 0, tbl[i].ty, tbl[i].dst, tbl[i].ae, tbl[i].fe,
                 tbl[i].rw, tbl[i].br, tbl[i].bus, tbl[i].exp);

        // Stack overflow: fifth nested call faults and leaves PC at the fourth target.
        do_reset();
        step("call1", 1,0, 3'b101,0,0,0,0,0, 8'h10, ex(0,0,0,0,0,0,0,0,8'h10));
        step("call2", 1,0, 3'b101,0,0,0,0,0, 8'h20, ex(0,0,0,0,0,0,0,0,8'h20));
        step("call3", 1,0, 3'b101,0,0,0,0,0, 8'h30, ex(0,0,0,0,0,0,0,0,8'h30));
        step("call4", 1,0, 3'b101,0,0,0,0,0, 8'h40, ex(0,0,0,0,0,0,0,0,8'h40));
        step("call5_fault", 1,0, 3'b101,0,0,0,0,0, 8'h50, ex(1,1,0,0,0,0,0,0,8'h40));
        step("halt_ignore", 1,0, 3'b000,3'd4,0,0,0,1, 8'h77, ex(1,1,0,0,0,0,0,0,8'h40));
        step("resume1", 0,1, 3'b000,0,0,0,0,0, 8'h00, ex(0,0,0,0,0,0,0,0,8'h00));

        // HALT op, ignored op, resume with a simultaneous op, then acceptance.
        step("jump9", 1,0, 3'b100,0,0,0,0,0, 8'h09, ex(0,0,0,0,0,0,0,0,8'h09));
        step("halt_op", 1,0, 3'b111,0,0,0,0,0, 8'h00, ex(1,0,0,0,0,0,0,0,8'h09));
        step("halted_ign", 1,0, 3'b100,0,0,0,0,0, 8'h55, ex(1,0,0,0,0,0,0,0,8'h09));
        step("resume_vld", 1,1, 3'b100,0,0,0,0,0, 8'h55, ex(0,0,0,0,0,0,0,0,8'h00));
        step("post_resume", 1,0, 3'b100,0,0,0,0,0, 8'h55, ex(0,0,0,0,0,0,0,0,8'h55));

        // Return on an empty stack.
        step("ret_empty", 1,0, 3'b110,0,0,0,0,0, 8'h00, ex(1,1,0,0,0,0,0,0,8'h55));
        step("resume2", 0,1, 3'b110,0,0,0,0,0, 8'h00, ex(0,0,0,0,0,0,0,0,8'h00));

        // Async reset while a write strobe is pending.
        step("wr_pulse", 1,0, 3'b010,3'd3,0,1,1,0, 8'h77, ex(0,0,0,0,0,8'h77,1,0,8'h01));
        uop_valid = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1 check("async_rst", outs(), ex(0,0,0,0,0,0,0,0,0));
        sys_rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_commit_sequencer.md
# bus_commit_sequencer

Consumer stage of the shared micro-bus. Each cycle it takes the resolved `write_bus_out` value plus the decoded micro-op controls (`reg_dst`, `minstr_type`, enables), and commits the value into the selected datapath or micro-architectural register. It owns the micro-PC and a 4-deep micro call/return stack, and runs a RUN/HALT sequencer with a valid/ready handshake toward the micro-decoder.

## Interface
Parameters:
- `MSTACK_DEPTH`, default 4: call/return stack entries; must be a power of 2.
- `MPC_W`, default `` `MPC_WIDTH ``: micro-PC width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `sys_clk` and `sys_rst_n`.
- `sys_clk`  in  1: system clock.
- `sys_rst_n`  in  1: async active-low reset.
- `uop_valid`  in  1: decoder presents a micro-op.
- `uop_ready`  out  1: stage accepts it. Commit occurs on `uop_valid && uop_ready`.
- `minstr_type`  in  3: micro-op class.
- `reg_dst`  in  `` `ADDR_WIDTH ``: destination map code.
- `alu_en`, `reg_file_en`, `reg_file_rw`, `is_branch`  in  1 each: bus write qualifiers.
- `write_bus_out`  in  `` `WRITE_WIDTH ``: resolved bus value.
- `resume`  in  1: leave HALT.
- `a_reg`, `b_reg`  out  `` `DATA_WIDTH ``: ALU operands.
- `reg_sel`  out  4: register-file index.
- `reg_wr_data`  out  `` `DATA_WIDTH ``: register-file write data.
- `reg_file_we`  out  1: one-cycle write strobe.
- `alu_start`  out  1: one-cycle ALU launch strobe.
- `m_pc`  out  `MPC_W`: address of the next micro-op.
- `halted`  out  1: sequencer is in HALT.
- `stack_err`  out  1: sticky stack-fault flag.

## Operation
`minstr_type` classes:
- 000 MOVE, 001 ALU, 010 REGFILE: commit the bus value per `reg_dst`, then `m_pc <= m_pc+1`.
- 011 BRANCH, 100 JUMP: `m_pc <= write_bus_out`. The bus already carries either the target or the fall-through `m_pc`.
- 101 CALL: push `m_pc+1`, then `m_pc <= write_bus_out`.
- 110 RET: pop into `m_pc`.
- 111 HALT: enter HALT; `m_pc` is held.

Destination commit (MOVE/ALU/REGFILE only):
- `A_REG_MAP` → `a_reg`, and `B_REG_MAP` → `b_reg`; both only if `alu_en`.
- `REG_SEL_MAP` → `reg_sel` (low 4 bits), only if `reg_file_en`.
- `REG_WR_DATA_MAP` → `reg_wr_data`, only if `reg_file_en && reg_file_rw`; this also sets `reg_file_we`.
- `M_PC_MAP` → `m_pc`, only if `is_branch`. This overrides the increment.
- Any other code, or a failed qualifier: no register changes, but `m_pc` still increments.

Strobes:
- `alu_start` pulses for every accepted ALU-class op.

Width rules:
- Bus values are zero-extended or truncated to the destination width.
- `m_pc+1` wraps modulo 2^`MPC_W`.

State machine (states RUN, HALT):
- Reset enters RUN.
- RUN → HALT on an accepted HALT op, or on a stack fault.
- HALT → RUN on `resume`. On that transition `m_pc <= 0`, the stack is cleared, and `stack_err` is cleared.
- `uop_ready` = (state == RUN).

Stack faults:
- CALL when the stack is full, or RET when it is empty, sets `stack_err` and enters HALT.
- The faulting op does not change `m_pc` or the stack.

## Timing
- All outputs are registered. A commit is visible the cycle after the accepting edge.
- `reg_file_we` and `alu_start` are high for exactly the one cycle after acceptance. `reg_file_we` is aligned with the updated `reg_wr_data`.
- Reset values:
  - `a_reg`, `b_reg`, `reg_sel`, `reg_wr_data`, `m_pc`: 0.
  - `reg_file_we`, `alu_start`, `halted`, `stack_err`: 0.
  - `uop_ready`: 1.
  - Stack pointer: 0.
- Back-to-back micro-ops are accepted every cycle in RUN; the throughput is one per cycle.
- In HALT, `uop_valid` is ignored.
- If `resume` and `uop_valid` occur in the same cycle while in HALT, the op is not accepted. The first acceptance can happen one cycle later.
- Reset asserted mid-operation clears everything immediately, including pending strobes, with no partial commit.

## Structure
- Shared package `ucpu_pkg`:
  - `minstr_t` enum with the 8 classes.
  - `seq_state_t` {RUN, HALT}.
  - `MSTACK_DEPTH_DEF`.
  - Destination map codes remain in `defines.vh`.
- Sub-module `mstack`: synchronous LIFO with push/pop/clear, `full`/`empty`, and a combinational top-of-stack.

## Test plan
- Reset, then MOVE with `A_REG_MAP`, `alu_en`=1, bus=0x5A → next cycle `a_reg`=0x5A and `m_pc`=1.
- REGFILE to `REG_WR_DATA_MAP` with `reg_file_en`=1 and `reg_file_rw`=0, bus=0x33 → `reg_wr_data` is unchanged, `reg_file_we` stays 0, and `m_pc` still increments. Repeat with `reg_file_rw`=1 → `reg_wr_data`=0x33 and `reg_file_we` is a single-cycle pulse.
- At `m_pc`=7, BRANCH with bus=0x20 → `m_pc`=0x20. JUMP with bus=0x03 → `m_pc`=0x03.
- CALL with bus=0x40 at `m_pc`=5 → `m_pc`=0x40; then RET → `m_pc`=6.
- Five nested CALLs → the 5th sets `stack_err` and `halted`, and `m_pc` equals the 4th target. Then `resume` → `m_pc`=0 and both flags clear.
- HALT op → `uop_ready`=0 and the following ops are ignored. Assert `resume` together with `uop_valid` → the op is not accepted that cycle and is accepted on the next one.
